// File: rtl/rtttl_pkg.sv
// Shared definitions for the RTTTL melody sequencer: song entry layout,
// sequencer states and tempo helpers.
package rtttl_pkg;

  localparam int ENTRY_W = 16;
  localparam int DUR_LSB = 0;
  localparam int DUR_W   = 3;
  localparam int DOT_BIT = 3;
  localparam int KEY_LSB = 4;
  localparam int KEY_W   = 4;
  localparam int OCT_LSB = 8;
  localparam int OCT_W   = 4;
  localparam int LEN_W   = 7;

  localparam logic [DUR_W-1:0] END_CODE_MIN = 3'd6;
  localparam logic [KEY_W-1:0] KEY_REST     = 4'd0;
  localparam logic [KEY_W-1:0] KEY_MAX      = 4'd12;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  // Mirrors the bit layout above, MSB first.
  typedef struct packed {
    logic [3:0]       rsvd;
    logic [OCT_W-1:0] octave;
    logic [KEY_W-1:0] key;
    logic             dot;
    logic [DUR_W-1:0] dur;
  } entry_t;

  // Clock cycles per 1/64-note tick: a quarter note is 16 ticks.
  function automatic int unsigned calc_tick_cycles(input int unsigned clk_hz,
                                                   input int unsigned bpm);
    return 32'((64'(clk_hz) * 64'd60) / (64'(bpm) * 64'd16));
  endfunction

  // Length in ticks for duration codes 0..5, with optional dot (x1.5).
  function automatic logic [LEN_W-1:0] note_len(input logic [DUR_W-1:0] dur,
                                                input logic dot);
    logic [LEN_W-1:0] base;
    base = 7'd64 >> dur;
    return base + (dot ? (base >> 1) : 7'd0);
  endfunction

endpackage

// File: rtl/rtttl_tick_gen.sv
// Free-running tick divider: one-cycle tick every TICK_CYCLES enabled cycles,
// restartable with a synchronous clear so notes begin on a tick boundary.
module rtttl_tick_gen #(
  parameter int TICK_CYCLES = 60
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: state registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rtttl_player.sv
// Melody sequencer: walks a song ROM of packed note entries and drives
// octave plus one-hot key to the tone generator, timed in 1/64-note ticks.
module rtttl_player
  import rtttl_pkg::*;
#(
  parameter int CLK_HZ = 1_000_000,
  parameter int BPM    = 160,
  parameter int ADDR_W = 6,
  parameter int ARTIC  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [3:0]        octave,
  output logic [15:0]       note,
  output logic              busy,
  output logic              done
);

  localparam int TICK_CYCLES = int'(calc_tick_cycles(CLK_HZ, BPM));
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  if (TICK_CYCLES < 2) begin : g_bad_tempo
    $error("rtttl_player: CLK_HZ/BPM give a tick period below 2 cycles");
  end

  state_t           state;
  entry_t           entry;
  logic [LEN_W-1:0] remain;
  logic             tick;
  logic             tick_clr;
  logic             tick_en;
  logic             is_end;
  logic             key_ok;
  logic             end_hit;
  logic             restart;
  logic             unused_rsvd;

  assign entry       = entry_t'(rom_data);
  assign unused_rsvd = ^entry.rsvd;
  assign busy        = (state != IDLE);
  assign tick_clr    = (state == LOAD);
  assign tick_en     = (state == PLAY);
  assign is_end      = (entry.dur >= END_CODE_MIN);
  assign key_ok      = (entry.key != KEY_REST) && (entry.key <= KEY_MAX);

  // Song ends on an end marker or after playing the last ROM address.
  // An end marker at address 0 never loops, so an empty song cannot spin silently.
  always_comb begin
    end_hit = 1'b0;
    restart = 1'b0;
    if (state == LOAD && is_end) begin
      end_hit = 1'b1;
      restart = loop_en && (rom_addr != '0);
    end else if (state == PLAY && tick && remain == 7'd1 && rom_addr == ADDR_LAST) begin
      end_hit = 1'b1;
      restart = loop_en;
    end
  end

  rtttl_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rom_addr <= '0;
      octave   <= '0;
      note     <= '0;
      done     <= 1'b0;
      remain   <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        rom_addr <= '0;
        octave   <= '0;
        note     <= '0;
      end else if (end_hit) begin
        rom_addr <= '0;
        if (restart) begin
          state <= FETCH;
        end else begin
          state  <= IDLE;
          done   <= 1'b1;
          octave <= '0;
          note   <= '0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state    <= FETCH;
              rom_addr <= '0;
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            // Rests keep the previous octave so the tone generator stays in range.
            if (key_ok) begin
              octave <= entry.octave;
              note   <= 16'd1 << entry.key;
            end else begin
              note <= '0;
            end
            remain <= note_len(entry.dur, entry.dot);
            state  <= PLAY;
          end
          PLAY: begin
            if (tick) begin
              remain <= remain - 1'b1;
              if (ARTIC != 0 && remain == 7'd2) note <= '0;
              if (remain == 7'd1) begin
                rom_addr <= rom_addr + 1'b1;
                state    <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
